rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource (e.g. one encoder/datapath slot) between ports 0-3.
- The requester vector is the same 4-bit request set a 4x2 priority encoder consumes. The arbiter adds rotating fairness, grant holding and a release handshake on top of it.
- It outputs a one-hot grant plus the 2-bit encoded index of the grant holder.

Parameters:
- MAX_HOLD, 16: maximum grant length in cycles; used only when ARB_TIMEOUT_EN is defined; legal range 2..255.
- RESET_PTR, 0: requester index that has highest priority after reset; legal range 0..3.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; bit k is requester k; level-sensitive
- done  input  1  one-cycle pulse from the current holder releasing the grant
- gnt  output  4  one-hot grant, registered
- gnt_idx  output  2  binary index of the holder, registered; 0 when gnt_valid=0
- gnt_valid  output  1  high while any grant is held
- timeout  output  1  one-cycle pulse on a forced release; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
  - state=IDLE, ptr=RESET_PTR, hold counter=0.
  - Asserting rst_n mid-grant clears all outputs immediately, without waiting for a clock edge.
- The FSM has two states, IDLE and GRANT.
- IDLE:
  - If req!=0 at a rising edge, select the first set bit searching ptr, ptr+1, ... with wrap 3->0.
  - Next cycle: gnt=onehot(sel), gnt_idx=sel, gnt_valid=1, state=GRANT.
  - Latency is one cycle from the req edge sample to gnt.
  - If req==0, stay in IDLE with outputs 0.
- GRANT:
  - Hold gnt unchanged while the holder keeps its request and does not release.
  - A release occurs on done=1, or on req[gnt_idx]=0 (holder withdrew). Both in the same cycle count as a single release.
  - On release, at the next edge: gnt=0, gnt_valid=0, gnt_idx=0, ptr=(gnt_idx+1) mod 4, state=IDLE.
- Re-arbitration:
  - There is always exactly one idle bubble cycle between consecutive grants.
  - Requests arriving or changing during GRANT are ignored until the next IDLE evaluation.
- done asserted in IDLE is ignored; it causes no state or ptr change.
- ptr changes only on a release and wraps 3->0. With all four requests held high and done pulsed each grant, grants cycle 0,1,2,3,0,...
- gnt is never multi-hot. gnt_valid is exactly equal to |gnt.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter clears on entry to GRANT and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 without a release, the arbiter forces a release on that edge: same actions as a normal release, ptr advances past the holder, and timeout=1 for exactly the following cycle.
  - A normal release on the same cycle takes precedence and sets timeout=0.
- Not defined: no counter is synthesized, timeout is tied 0, and a grant is held indefinitely until released.

Test Plan:
1. Reset with req=4'b1111 held -> outputs 0 while rst_n=0. First edge after release -> gnt=0001, gnt_idx=0.
2. Fairness: req=4'b1010, ptr=0 -> gnt=0010, idx=1. Pulse done -> 1 idle cycle, then gnt=1000, idx=3. Pulse done -> gnt=0010 again (ptr wrapped 0).
3. Holder withdraw: grant to 2 (gnt=0100), drop req[2] with no done -> gnt=0 next cycle, ptr=3. With req=4'b0001 -> gnt=0001.
4. Ignored done / simultaneous release: done pulse in IDLE with req=0 -> no change, ptr stays. In GRANT, done=1 and req[idx]=0 in the same cycle -> single release, ptr advances by exactly one position.
5. Async reset mid-grant: gnt=0100, drop rst_n between edges -> gnt=0, gnt_valid=0 immediately. After release -> ptr=RESET_PTR.
6. With ARB_TIMEOUT_EN and MAX_HOLD=4: hold req[1] with no done -> gnt=0010 for 4 cycles, then gnt=0, timeout=1 for one cycle, next grant goes to the next requester. Without the macro -> gnt held for 100 cycles, timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant holding and a release handshake.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD  = 16,
    parameter int unsigned RESET_PTR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam int unsigned CNT_W = 8;

    if (MAX_HOLD < 2 || MAX_HOLD > 255 || RESET_PTR > 3) begin : g_param_check
        $error("rr_arbiter4: parameter out of range");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     state_q;
    logic [1:0] ptr_q;
    logic [1:0] sel_c;
    logic       release_c;
    logic       force_c;

    // First set request at or after ptr, wrapping 3 -> 0; lowest offset wins.
    always_comb begin
        sel_c = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr_q + 2'(i)]) begin
                sel_c = ptr_q + 2'(i);
            end
        end
    end

    assign release_c = done | ~req[gnt_idx];

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] hold_q;

    assign force_c = ~release_c && (hold_q == CNT_W'(MAX_HOLD - 1));
`else
    logic [CNT_W-1:0] hold_q;

    assign hold_q  = '0;
    assign force_c = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'(RESET_PTR);
            gnt       <= 4'b0000;
            gnt_idx   <= 2'd0;
            gnt_valid <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_q    <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        gnt       <= 4'b0001 << sel_c;
                        gnt_idx   <= sel_c;
                        gnt_valid <= 1'b1;
                        state_q   <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_q    <= '0;
`endif
                    end
                end
                ST_GRANT: begin
                    // A normal release beats a timeout on the same edge.
                    if (release_c || force_c) begin
                        gnt       <= 4'b0000;
                        gnt_idx   <= 2'd0;
                        gnt_valid <= 1'b0;
                        ptr_q     <= gnt_idx + 2'd1;
                        state_q   <= ST_IDLE;
`ifdef ARB_TIMEOUT_EN
                        timeout   <= force_c;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        hold_q    <= hold_q + CNT_W'(1);
`endif
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: directed scenarios plus randomized traffic
// compared against a holder/pointer reference model.
module tb_rr_arbiter4;

    localparam int unsigned MAX_HOLD  = 4;
    localparam int unsigned RESET_PTR = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // Reference model: who holds the grant (-1 = nobody), rotation start, grant age.
    int m_holder = -1;
    int m_ptr    = RESET_PTR;
    int m_age    = 0;
    bit m_to     = 1'b0;

    rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .RESET_PTR(RESET_PTR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_holder = -1;
        m_ptr    = RESET_PTR;
        m_age    = 0;
        m_to     = 1'b0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic d);
        bit rel;
        bit frc;
        m_to = 1'b0;
        if (m_holder < 0) begin
            for (int k = 0; k < 4; k++) begin
                if (r[(m_ptr + k) % 4]) begin
                    m_holder = (m_ptr + k) % 4;
                    m_age    = 0;
                    break;
                end
            end
        end else begin
            rel = d || !r[m_holder];
            frc = 1'b0;
`ifdef ARB_TIMEOUT_EN
            frc = !rel && (m_age == int'(MAX_HOLD) - 1);
`endif
            if (rel || frc) begin
                m_ptr    = (m_holder + 1) % 4;
                m_holder = -1;
                m_to     = frc;
            end else begin
                m_age++;
            end
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        logic [1:0] ix;
        g  = (m_holder < 0) ? 4'b0000 : 4'(1 << m_holder);
        ix = (m_holder < 0) ? 2'd0 : 2'(m_holder);
        return {g, ix, (m_holder >= 0), m_to};
    endfunction

    // Drive inputs, take one rising edge, advance the model, settle.
    task automatic step(input logic [3:0] r, input logic d);
        req  = r;
        done = d;
        @(posedge clk);
        model_edge(r, d);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        done  = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'h00) begin
                failures++;
                $display("FAIL reset_hold%0d got=%b exp=%b", i, {gnt, gnt_idx, gnt_valid, timeout}, 8'h00);
            end
        end
        rst_n = 1'b1;
        step(4'b1111, 1'b0);
        checks++;
        if ({gnt, gnt_idx, gnt_valid} !== {4'b0001, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_first_grant got=%b exp=%b", {gnt, gnt_idx, gnt_valid}, {4'b0001, 2'd0, 1'b1});
        end
    endtask

    task automatic test_fairness();
        logic [3:0] exp_g [5] = '{4'b0010, 4'b0000, 4'b1000, 4'b0000, 4'b0010};
        logic       dn    [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'b1010, dn[i]);
            checks++;
            if (gnt !== exp_g[i] || {gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                failures++;
                $display("FAIL fairness%0d got=%b exp_gnt=%b model=%b", i, {gnt, gnt_idx, gnt_valid, timeout}, exp_g[i], exp_vec());
            end
        end
    endtask

    task automatic test_withdraw();
        logic [3:0] rq    [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001};
        logic [3:0] exp_g [4] = '{4'b0100, 4'b0100, 4'b0000, 4'b0001};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            step(rq[i], 1'b0);
            checks++;
            if (gnt !== exp_g[i] || {gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                failures++;
                $display("FAIL withdraw%0d got=%b exp_gnt=%b model=%b", i, {gnt, gnt_idx, gnt_valid, timeout}, exp_g[i], exp_vec());
            end
        end
    endtask

    task automatic test_done_idle_and_double_release();
        logic [3:0] rq    [5] = '{4'b0000, 4'b0000, 4'b1001, 4'b1000, 4'b1111};
        logic       dn    [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] exp_g [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(rq[i], dn[i]);
            checks++;
            if (gnt !== exp_g[i] || {gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                failures++;
                $display("FAIL done_idle%0d got=%b exp_gnt=%b model=%b", i, {gnt, gnt_idx, gnt_valid, timeout}, exp_g[i], exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        step(4'b0100, 1'b0);
        checks++;
        if (gnt !== 4'b0100) begin
            failures++;
            $display("FAIL async_pre got=%b exp=%b", gnt, 4'b0100);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({gnt, gnt_idx, gnt_valid, timeout} !== 8'h00) begin
            failures++;
            $display("FAIL async_clear got=%b exp=%b", {gnt, gnt_idx, gnt_valid, timeout}, 8'h00);
        end
        rst_n = 1'b1;
        step(4'b1111, 1'b0);
        checks++;
        if ({gnt, gnt_idx, gnt_valid} !== {4'b0001, 2'd0, 1'b1}) begin
            failures++;
            $display("FAIL async_ptr got=%b exp=%b", {gnt, gnt_idx, gnt_valid}, {4'b0001, 2'd0, 1'b1});
        end
    endtask

    task automatic test_timeout();
        apply_reset();
`ifdef ARB_TIMEOUT_EN
        begin
            // Requester 1 holds for MAX_HOLD cycles, then forced out; 2 is next.
            logic [7:0] exp_seq [7] = '{
                {4'b0010, 2'd1, 1'b1, 1'b0}, {4'b0010, 2'd1, 1'b1, 1'b0},
                {4'b0010, 2'd1, 1'b1, 1'b0}, {4'b0010, 2'd1, 1'b1, 1'b0},
                {4'b0000, 2'd0, 1'b0, 1'b1}, {4'b0100, 2'd2, 1'b1, 1'b0},
                {4'b0100, 2'd2, 1'b1, 1'b0}};
            for (int i = 0; i < 7; i++) begin
                step(4'b0110, 1'b0);
                checks++;
                if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_seq[i] ||
                    {gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                    failures++;
                    $display("FAIL timeout%0d got=%b exp=%b model=%b", i, {gnt, gnt_idx, gnt_valid, timeout}, exp_seq[i], exp_vec());
                end
            end
        end
`else
        for (int i = 0; i < 100; i++) begin
            step(4'b0010, 1'b0);
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== {4'b0010, 2'd1, 1'b1, 1'b0} ||
                {gnt, gnt_idx, gnt_valid, timeout} !== exp_vec()) begin
                failures++;
                $display("FAIL no_timeout%0d got=%b exp=%b", i, {gnt, gnt_idx, gnt_valid, timeout}, {4'b0010, 2'd1, 1'b1, 1'b0});
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       d;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            r = 4'($urandom);
            // Usually keep the holder requesting so grants last a few cycles.
            if (m_holder >= 0 && $urandom_range(0, 3) != 0) begin
                r[m_holder] = 1'b1;
            end
            d = ($urandom_range(0, 4) == 0);
            step(r, d);
            checks++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== exp_vec() ||
                !$onehot0(gnt) || gnt_valid !== (|gnt)) begin
                failures++;
                $display("FAIL random%0d req=%b done=%b got=%b exp=%b", i, r, d, {gnt, gnt_idx, gnt_valid, timeout}, exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        test_reset();
        test_fairness();
        test_withdraw();
        test_done_idle_and_double_release();
        test_async_reset();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
